mmss_countdown: RTL and testbench
=================================

MMSS_COUNTDOWN -- requirements
Module: mmss_countdown

Interface
Parameters:
REQ-001 The block SHALL have parameter MIN_DIGITS, default 2, giving the number of BCD minute digits; legal range 1..3.
REQ-002 The block SHALL have parameter TICK_DIV, default 100, giving clock cycles per one-second decrement; legal range 2..2^20.
Ports:
REQ-003 The block SHALL have port clock, input, 1 bit: the single clock, with all state on the rising edge.
REQ-004 The block SHALL have port clr, input, 1 bit: synchronous, active-high reset.
REQ-005 The block SHALL have port data, input, 4 bits: keypad BCD digit.
REQ-006 The block SHALL have port load, input, 1 bit: shift data into the display on this cycle.
REQ-007 The block SHALL have ports start and stop, input, 1 bit each: level-sampled control requests.
REQ-008 The block SHALL have ports sec_ones and sec_tens, output, 4 bits each: BCD seconds digits.
REQ-009 The block SHALL have port mins, output, 4*MIN_DIGITS bits: BCD minutes, least-significant digit in bits [3:0].
REQ-010 The block SHALL have port zero, output, 1 bit: all digits equal 0, combinational from the digit registers.
REQ-011 The block SHALL have port running, output, 1 bit: high while in state RUN.
REQ-012 The block SHALL have port done, output, 1 bit: one-cycle pulse when the countdown reaches 0.

Function
REQ-013 The block SHALL implement states IDLE, RUN, PAUSE and DONE in an FSM.
REQ-014 In IDLE or PAUSE, load=1 with data<=9 SHALL shift the digits: mins[k]<=mins[k-1], mins[0]<=sec_tens, sec_tens<=sec_ones, sec_ones<=data; the top minute digit is discarded.
REQ-015 load with data>9, or load in RUN/DONE, SHALL be ignored, with no digit change.
REQ-016 sec_tens SHALL accept any loaded value 0..9, so 0:99 is legal; no normalisation occurs.
REQ-017 Control priority per cycle SHALL be clr > stop > load > start; a load cycle in IDLE/PAUSE ignores start.
REQ-018 In IDLE, start with zero=0 SHALL go to RUN and clear the prescaler; start with zero=1 SHALL stay in IDLE.
REQ-019 In RUN, the prescaler SHALL increment each cycle; at TICK_DIV-1 it wraps to 0 and the digits decrement by one second, so the first decrement occurs TICK_DIV cycles after entering RUN.
REQ-020 The decrement SHALL work as follows: if sec_ones>0, decrement it; else set sec_ones=9 and borrow from sec_tens. If sec_tens>0, decrement it; else set sec_tens=5 and borrow from mins. Mins decrements as multi-digit BCD, each 0 digit becoming 9 with a borrow.
REQ-021 A decrement producing all-zero digits SHALL transition RUN->DONE on that edge.
REQ-022 done=1 SHALL be asserted exactly during the single DONE cycle; DONE SHALL always go to IDLE on the next edge, and all inputs except clr are ignored in DONE.
REQ-023 In RUN, stop SHALL go to PAUSE, holding the digits and the prescaler value.
REQ-024 In PAUSE, start SHALL return to RUN, with the prescaler resuming from its held value.
REQ-025 In PAUSE, stop SHALL go to IDLE and clear all digits to 0.
REQ-026 In IDLE, stop SHALL clear all digits to 0 and remain in IDLE.
REQ-027 If stop and a tick coincide in RUN, stop SHALL win: no decrement, go to PAUSE.
REQ-028 Digits SHALL never hold a non-BCD value; the block never underflows below 0 and never decrements in IDLE, PAUSE or DONE.

Reset
REQ-029 clr=1 at a clock edge SHALL set state=IDLE, all digits=0, prescaler=0, done=0 and running=0, regardless of state, including mid-RUN or DONE.
REQ-030 After reset, zero=1.

Verification (TICK_DIV=4, MIN_DIGITS=2)
REQ-031 The bench SHALL cover load entry: load 1, 3, 0 -> mins=8'h01, sec_tens=3, sec_ones=0; then load data=4'hC -> unchanged.
REQ-032 The bench SHALL cover countdown with borrow: preset 10:00, start -> running=1; 4 cycles later 09:59; 4 cycles after that 09:58.
REQ-033 The bench SHALL cover terminal count: preset 00:01, start -> after 4 cycles digits 00:00, zero=1, done=1 for exactly one cycle, then IDLE with running=0.
REQ-034 The bench SHALL cover 99-second entry: load 9, 9, start -> 00:98 after 4 cycles; at 00:90 the next tick gives 00:89.
REQ-035 The bench SHALL cover pause/resume/cancel: stop at prescaler=2 -> PAUSE, digits held for 20 cycles; start -> decrement 2 cycles later; stop, stop -> IDLE, 00:00.
REQ-036 The bench SHALL cover reset and corners: clr asserted mid-RUN at 05:30 -> next edge 00:00, IDLE, done=0; start with zero=1 -> running stays 0; start+stop together in IDLE -> digits cleared, no RUN.

Source files
------------

// File: rtl/mmss_countdown.sv
// BCD minutes:seconds countdown timer with keypad shift-in entry.
// A four-state FSM drives a prescaler; each prescaler wrap subtracts one second.
module mmss_countdown #(
  parameter int MIN_DIGITS = 2,
  parameter int TICK_DIV   = 100
) (
  input  logic                    clock,
  input  logic                    clr,
  input  logic [3:0]              data,
  input  logic                    load,
  input  logic                    start,
  input  logic                    stop,
  output logic [3:0]              sec_ones,
  output logic [3:0]              sec_tens,
  output logic [4*MIN_DIGITS-1:0] mins,
  output logic                    zero,
  output logic                    running,
  output logic                    done
);

  localparam int PW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] PRESC_MAX = PW'(TICK_DIV - 1);

  typedef enum logic [1:0] {IDLE, RUN, PAUSE, DONE} state_t;

  state_t                      state, next_state;
  logic [PW-1:0]               presc, next_presc;
  logic [3:0]                  ones_q, tens_q, next_ones, next_tens;
  logic [MIN_DIGITS-1:0][3:0]  min_q, next_min;

  logic [3:0]                  dec_ones, dec_tens;
  logic [MIN_DIGITS-1:0][3:0]  dec_min, sh_min;
  logic                        dec_zero;

  assign sec_ones = ones_q;
  assign sec_tens = tens_q;
  assign mins     = min_q;
  assign zero     = (ones_q == 4'd0) && (tens_q == 4'd0) && (min_q == '0);
  assign running  = (state == RUN);
  assign done     = (state == DONE);

  // One-second BCD decrement: seconds borrow at 0 -> x:59, minutes ripple 0 -> 9.
  always_comb begin : dec_logic
    logic borrow;
    dec_ones = ones_q;
    dec_tens = tens_q;
    dec_min  = min_q;
    borrow   = 1'b0;
    if (ones_q != 4'd0) begin
      dec_ones = ones_q - 4'd1;
    end else begin
      dec_ones = 4'd9;
      if (tens_q != 4'd0) begin
        dec_tens = tens_q - 4'd1;
      end else begin
        dec_tens = 4'd5;
        borrow   = 1'b1;
      end
    end
    for (int k = 0; k < MIN_DIGITS; k++) begin
      if (borrow) begin
        if (min_q[k] == 4'd0) begin
          dec_min[k] = 4'd9;
        end else begin
          dec_min[k] = min_q[k] - 4'd1;
          borrow     = 1'b0;
        end
      end
    end
    dec_zero = (dec_ones == 4'd0) && (dec_tens == 4'd0) && (dec_min == '0);
  end

  always_comb begin
    sh_min = min_q;
    for (int k = 1; k < MIN_DIGITS; k++) begin
      sh_min[k] = min_q[k-1];
    end
    sh_min[0] = tens_q;
  end

  always_comb begin
    next_state = state;
    next_presc = presc;
    next_ones  = ones_q;
    next_tens  = tens_q;
    next_min   = min_q;
    case (state)
      IDLE, PAUSE: begin
        if (stop) begin
          next_state = IDLE;
          next_ones  = 4'd0;
          next_tens  = 4'd0;
          next_min   = '0;
        end else if (load) begin
          if (data <= 4'd9) begin
            next_ones = data;
            next_tens = ones_q;
            next_min  = sh_min;
          end
        end else if (start && !zero) begin
          // Resuming from PAUSE keeps the partially elapsed second.
          next_state = RUN;
          if (state == IDLE) next_presc = '0;
        end
      end
      RUN: begin
        if (stop) begin
          next_state = PAUSE;
        end else if (presc == PRESC_MAX) begin
          next_presc = '0;
          next_ones  = dec_ones;
          next_tens  = dec_tens;
          next_min   = dec_min;
          if (dec_zero) next_state = DONE;
        end else begin
          next_presc = presc + 1'b1;
        end
      end
      DONE: next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (clr) begin
      state  <= IDLE;
      presc  <= '0;
      ones_q <= 4'd0;
      tens_q <= 4'd0;
      min_q  <= '0;
    end else begin
      state  <= next_state;
      presc  <= next_presc;
      ones_q <= next_ones;
      tens_q <= next_tens;
      min_q  <= next_min;
    end
  end

endmodule

// File: tb/tb_mmss_countdown.sv
// Directed bench for mmss_countdown (TICK_DIV=4, MIN_DIGITS=2): a vector
// table for entry/countdown/reset cases plus a pause/resume/cancel sequence.
module tb_mmss_countdown;

  logic       clock = 1'b0;
  logic       clr = 1'b0, load = 1'b0, start = 1'b0, stop = 1'b0;
  logic [3:0] data = 4'd0;
  logic [3:0] sec_ones, sec_tens;
  logic [7:0] mins;
  logic       zero, running, done;

  int checks = 0;
  int errors = 0;

  mmss_countdown #(.MIN_DIGITS(2), .TICK_DIV(4)) dut (
    .clock(clock), .clr(clr), .data(data), .load(load), .start(start), .stop(stop),
    .sec_ones(sec_ones), .sec_tens(sec_tens), .mins(mins),
    .zero(zero), .running(running), .done(done)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic       clr;
    logic [3:0] data;
    logic       load, start, stop;
    logic [7:0] e_mins;
    logic [3:0] e_tens, e_ones;
    logic       e_zero, e_run, e_done;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(logic c, logic [3:0] d, logic l, logic sa, logic so,
                              logic [7:0] m, logic [3:0] t, logic [3:0] o,
                              logic z, logic r, logic dn);
    vec_t v;
    v.clr = c; v.data = d; v.load = l; v.start = sa; v.stop = so;
    v.e_mins = m; v.e_tens = t; v.e_ones = o;
    v.e_zero = z; v.e_run = r; v.e_done = dn;
    return v;
  endfunction

  // Drive one cycle of inputs, then sample 1 time unit after the edge.
  task automatic apply_stimulus(input logic c, input logic [3:0] d, input logic l,
                                input logic sa, input logic so);
    clr = c; data = d; load = l; start = sa; stop = so;
    @(posedge clock);
    #1;
  endtask

  task automatic check_output(input string name, input logic [7:0] m, input logic [3:0] t,
                              input logic [3:0] o, input logic z, input logic r,
                              input logic dn);
    logic [18:0] act, exp_v;
    act   = {mins, sec_tens, sec_ones, zero, running, done};
    exp_v = {m, t, o, z, r, dn};
    checks++;
    if (act !== exp_v) begin
      errors++;
      $display("[TB] FAIL %s: got mins=%h tens=%h ones=%h zero=%b run=%b done=%b, want mins=%h tens=%h ones=%h zero=%b run=%b done=%b",
               name, mins, sec_tens, sec_ones, zero, running, done, m, t, o, z, r, dn);
    end
  endtask

  initial begin
    // Reset and keypad entry
    vecs.push_back(mk(1, 0, 0, 0, 0, 8'h00, 0, 0, 1, 0, 0));
    vecs.push_back(mk(0, 1, 1, 0, 0, 8'h00, 0, 1, 0, 0, 0));
    vecs.push_back(mk(0, 3, 1, 0, 0, 8'h00, 1, 3, 0, 0, 0));
    vecs.push_back(mk(0, 0, 1, 0, 0, 8'h01, 3, 0, 0, 0, 0));
    vecs.push_back(mk(0, 4'hC, 1, 0, 0, 8'h01, 3, 0, 0, 0, 0));
    vecs.push_back(mk(0, 5, 1, 1, 0, 8'h13, 0, 5, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 1, 8'h00, 0, 0, 1, 0, 0));
    vecs.push_back(mk(0, 0, 0, 1, 0, 8'h00, 0, 0, 1, 0, 0));
    vecs.push_back(mk(0, 1, 1, 0, 0, 8'h00, 0, 1, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 1, 1, 8'h00, 0, 0, 1, 0, 0));
    // 10:00 countdown with minute borrow
    vecs.push_back(mk(0, 1, 1, 0, 0, 8'h00, 0, 1, 0, 0, 0));
    vecs.push_back(mk(0, 0, 1, 0, 0, 8'h00, 1, 0, 0, 0, 0));
    vecs.push_back(mk(0, 0, 1, 0, 0, 8'h01, 0, 0, 0, 0, 0));
    vecs.push_back(mk(0, 0, 1, 0, 0, 8'h10, 0, 0, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 1, 0, 8'h10, 0, 0, 0, 1, 0));
    for (int i = 0; i < 3; i++) vecs.push_back(mk(0, 0, 0, 0, 0, 8'h10, 0, 0, 0, 1, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 8'h09, 5, 9, 0, 1, 0));
    for (int i = 0; i < 3; i++) vecs.push_back(mk(0, 0, 0, 0, 0, 8'h09, 5, 9, 0, 1, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 8'h09, 5, 8, 0, 1, 0));
    vecs.push_back(mk(1, 0, 0, 0, 0, 8'h00, 0, 0, 1, 0, 0));
    // Terminal count from 00:01; load during DONE is ignored
    vecs.push_back(mk(0, 1, 1, 0, 0, 8'h00, 0, 1, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 1, 0, 8'h00, 0, 1, 0, 1, 0));
    for (int i = 0; i < 3; i++) vecs.push_back(mk(0, 0, 0, 0, 0, 8'h00, 0, 1, 0, 1, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 8'h00, 0, 0, 1, 0, 1));
    vecs.push_back(mk(0, 7, 1, 0, 0, 8'h00, 0, 0, 1, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 8'h00, 0, 0, 1, 0, 0));
    // 99-second entry
    vecs.push_back(mk(0, 9, 1, 0, 0, 8'h00, 0, 9, 0, 0, 0));
    vecs.push_back(mk(0, 9, 1, 0, 0, 8'h00, 9, 9, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 1, 0, 8'h00, 9, 9, 0, 1, 0));
    for (int i = 0; i < 3; i++) vecs.push_back(mk(0, 0, 0, 0, 0, 8'h00, 9, 9, 0, 1, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 8'h00, 9, 8, 0, 1, 0));
    // 00:90 -> 00:89
    vecs.push_back(mk(1, 0, 0, 0, 0, 8'h00, 0, 0, 1, 0, 0));
    vecs.push_back(mk(0, 9, 1, 0, 0, 8'h00, 0, 9, 0, 0, 0));
    vecs.push_back(mk(0, 0, 1, 0, 0, 8'h00, 9, 0, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 1, 0, 8'h00, 9, 0, 0, 1, 0));
    for (int i = 0; i < 3; i++) vecs.push_back(mk(0, 0, 0, 0, 0, 8'h00, 9, 0, 0, 1, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 8'h00, 8, 9, 0, 1, 0));
    // clr mid-RUN at 05:30
    vecs.push_back(mk(1, 0, 0, 0, 0, 8'h00, 0, 0, 1, 0, 0));
    vecs.push_back(mk(0, 5, 1, 0, 0, 8'h00, 0, 5, 0, 0, 0));
    vecs.push_back(mk(0, 3, 1, 0, 0, 8'h00, 5, 3, 0, 0, 0));
    vecs.push_back(mk(0, 0, 1, 0, 0, 8'h05, 3, 0, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 1, 0, 8'h05, 3, 0, 0, 1, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 8'h05, 3, 0, 0, 1, 0));
    vecs.push_back(mk(1, 0, 0, 1, 0, 8'h00, 0, 0, 1, 0, 0));

    foreach (vecs[i]) begin
      apply_stimulus(vecs[i].clr, vecs[i].data, vecs[i].load, vecs[i].start, vecs[i].stop);
      check_output($sformatf("vec%0d", i), vecs[i].e_mins, vecs[i].e_tens, vecs[i].e_ones,
                   vecs[i].e_zero, vecs[i].e_run, vecs[i].e_done);
    end

    // Pause at prescaler=2, hold, resume, then stop on a tick cycle
    apply_stimulus(1, 0, 0, 0, 0);
    apply_stimulus(0, 3, 1, 0, 0);
    apply_stimulus(0, 0, 1, 0, 0);
    check_output("preset_0030", 8'h00, 3, 0, 0, 0, 0);
    apply_stimulus(0, 0, 0, 1, 0);
    apply_stimulus(0, 0, 0, 0, 0);
    apply_stimulus(0, 0, 0, 0, 0);
    apply_stimulus(0, 0, 0, 0, 1);
    check_output("pause_enter", 8'h00, 3, 0, 0, 0, 0);
    for (int i = 0; i < 20; i++) begin
      apply_stimulus(0, 0, 0, 0, 0);
      check_output($sformatf("pause_hold%0d", i), 8'h00, 3, 0, 0, 0, 0);
    end
    apply_stimulus(0, 0, 0, 1, 0);
    check_output("resume", 8'h00, 3, 0, 0, 1, 0);
    apply_stimulus(0, 0, 0, 0, 0);
    check_output("resume_p3", 8'h00, 3, 0, 0, 1, 0);
    apply_stimulus(0, 0, 0, 0, 0);
    check_output("resume_tick", 8'h00, 2, 9, 0, 1, 0);
    for (int i = 0; i < 3; i++) apply_stimulus(0, 0, 0, 0, 0);
    check_output("pre_tick", 8'h00, 2, 9, 0, 1, 0);
    apply_stimulus(0, 0, 0, 0, 1);
    check_output("stop_wins_tick", 8'h00, 2, 9, 0, 0, 0);
    apply_stimulus(0, 0, 0, 1, 0);
    check_output("resume_at_max", 8'h00, 2, 9, 0, 1, 0);
    apply_stimulus(0, 0, 0, 0, 0);
    check_output("held_max_tick", 8'h00, 2, 8, 0, 1, 0);
    apply_stimulus(0, 0, 0, 0, 1);
    check_output("stop_to_pause", 8'h00, 2, 8, 0, 0, 0);
    apply_stimulus(0, 0, 0, 0, 1);
    check_output("stop_cancel", 8'h00, 0, 0, 1, 0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
